matrix_result_serializer: RTL

MATRIX_RESULT_SERIALIZER -- requirements
Module: matrix_result_serializer

---
 rtl/matrix_pkg.sv | 31 +++
 rtl/matrix_result_serializer_elem_byte_mux.sv | 47 ++++
 rtl/matrix_result_serializer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/matrix_pkg.sv
// -----------------------------------------------------------------------------
// matrix_pkg
// Shared definitions for the matrix result serializer.
//   N_ELEM         : number of result elements (3x3 matrix)
//   ELEM_W         : width of each result element
//   BYTES_PER_ELEM : bytes emitted per element (low byte first, zero padded)
//   FRAME_BYTES    : data bytes per frame
//   state_t        : serializer FSM states; CSUM exists only when
//                    MATRIX_SER_CHECKSUM_EN is defined
// -----------------------------------------------------------------------------
package matrix_pkg;

    localparam int N_ELEM         = 9;
    localparam int ELEM_W         = 18;
    localparam int BYTES_PER_ELEM = 3;
    localparam int FRAME_BYTES    = N_ELEM * BYTES_PER_ELEM;

`ifdef MATRIX_SER_CHECKSUM_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        CSUM = 2'd2
    } state_t;
`else
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;
`endif

endpackage

// File: rtl/matrix_result_serializer_elem_byte_mux.sv
// -----------------------------------------------------------------------------
// elem_byte_mux
// Purely combinational byte selector: picks element elem_idx out of the packed
// frame and returns byte lane `lane` of it, zero padded above ELEM_W.
// Ports:
//   c_flat   : packed elements, element i at [i*ELEM_W +: ELEM_W]
//   elem_idx : element to select
//   lane     : byte lane within the element (0 = bits [7:0])
//   byte_out : selected 8-bit value
// -----------------------------------------------------------------------------
module elem_byte_mux
    import matrix_pkg::BYTES_PER_ELEM;
#(
    parameter int N_ELEM = 9,
    parameter int ELEM_W = 18,
    parameter int IDX_W  = $clog2(N_ELEM),
    parameter int LANE_W = $clog2(BYTES_PER_ELEM)
) (
    input  logic [N_ELEM*ELEM_W-1:0] c_flat,
    input  logic [IDX_W-1:0]         elem_idx,
    input  logic [LANE_W-1:0]        lane,
    output logic [7:0]               byte_out
);

    localparam int PAD_W = BYTES_PER_ELEM * 8;

    logic [ELEM_W-1:0] elem;
    logic [PAD_W-1:0]  padded;

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise unmatched indices infer latches.
    always_comb begin
        elem = '0;
        for (int i = 0; i < N_ELEM; i++) begin
            if (elem_idx == IDX_W'(i)) elem = c_flat[i*ELEM_W +: ELEM_W];
        end

        // Zero-extension supplies the padding bits of the top lane.
        padded = PAD_W'(elem);

        byte_out = '0;
        for (int j = 0; j < BYTES_PER_ELEM; j++) begin
            if (lane == LANE_W'(j)) byte_out = padded[j*8 +: 8];
        end
    end

endmodule

// File: rtl/matrix_result_serializer.sv
// -----------------------------------------------------------------------------
// matrix_result_serializer
// Captures a matrix multiplier result frame on the rising edge of `done` and
// streams it out as bytes over a valid/ready handshake, element 0 first, each
// element low byte first.
// Optional feature: define MATRIX_SER_CHECKSUM_EN to append one byte holding
// the XOR of all data bytes.
// Ports:
//   clk       : clock, rising edge
//   reset     : asynchronous active-high reset
//   done      : level completion flag; only its rising edge starts a frame
//   c_flat    : packed results, element i at [i*ELEM_W +: ELEM_W]
//   out_data  : current output byte (0 when idle)
//   out_valid : out_data holds a valid byte
//   out_ready : downstream accepts the byte this cycle
//   busy      : frame in progress
//   overrun   : sticky, a done rising edge arrived while busy
// -----------------------------------------------------------------------------
module matrix_result_serializer
    import matrix_pkg::state_t;
    import matrix_pkg::IDLE;
    import matrix_pkg::SEND;
`ifdef MATRIX_SER_CHECKSUM_EN
    import matrix_pkg::CSUM;
`endif
    import matrix_pkg::BYTES_PER_ELEM;
    import matrix_pkg::FRAME_BYTES;
#(
    parameter int N_ELEM = matrix_pkg::N_ELEM,
    parameter int ELEM_W = matrix_pkg::ELEM_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     done,
    input  logic [N_ELEM*ELEM_W-1:0] c_flat,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     overrun
);

    localparam int IDX_W  = $clog2(N_ELEM);
    localparam int LANE_W = $clog2(BYTES_PER_ELEM);
    localparam int CNT_W  = $clog2(FRAME_BYTES);

    state_t                   state, state_nxt;
    logic                     done_q;
    logic                     start_evt;
    logic                     capture;
    logic                     xfer;
    logic                     last_byte;
    logic [N_ELEM*ELEM_W-1:0] frame_q;
    logic [IDX_W-1:0]         elem_idx;
    logic [LANE_W-1:0]        lane;
    logic [CNT_W-1:0]         byte_idx;
    logic [7:0]               mux_byte;

    assign start_evt = done & ~done_q;
    assign capture   = (state == IDLE) && start_evt;
    assign xfer      = out_valid & out_ready;
    assign last_byte = (byte_idx == CNT_W'(FRAME_BYTES - 1));

    // ---- state register ----------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // ---- next-state logic --------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (capture) state_nxt = SEND;
`ifdef MATRIX_SER_CHECKSUM_EN
            SEND: if (xfer && last_byte) state_nxt = CSUM;
            CSUM: if (xfer) state_nxt = IDLE;
`else
            SEND: if (xfer && last_byte) state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // ---- output logic ------------------------------------------------------
    // Outputs decode the state directly, so reset clears them immediately.
`ifdef MATRIX_SER_CHECKSUM_EN
    logic [7:0] csum_q;
`endif

    always_comb begin
        out_valid = 1'b0;
        busy      = 1'b0;
        out_data  = '0;
        case (state)
            SEND: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_data  = mux_byte;
            end
`ifdef MATRIX_SER_CHECKSUM_EN
            CSUM: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_data  = csum_q;
            end
`endif
            default: ;
        endcase
    end

    // ---- edge detect, byte position, overrun --------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_q   <= 1'b0;
            elem_idx <= '0;
            lane     <= '0;
            byte_idx <= '0;
            overrun  <= 1'b0;
        end else begin
            done_q <= done;
            // A start edge seen in any non-idle state is dropped and flagged,
            // including the edge that completes the last transfer.
            if (start_evt && (state != IDLE)) overrun <= 1'b1;

            if (capture || ((state == SEND) && xfer && last_byte)) begin
                elem_idx <= '0;
                lane     <= '0;
                byte_idx <= '0;
            end else if ((state == SEND) && xfer) begin
                byte_idx <= byte_idx + CNT_W'(1);
                if (lane == LANE_W'(BYTES_PER_ELEM - 1)) begin
                    lane     <= '0;
                    elem_idx <= elem_idx + IDX_W'(1);
                end else begin
                    lane <= lane + LANE_W'(1);
                end
            end
        end
    end

    // ---- frame buffer ------------------------------------------------------
    // NOTE: the frame buffer is pure datapath and is deliberately not reset;
    // it is only ever read after a capture has loaded it.
    always_ff @(posedge clk) begin
        if (capture) frame_q <= c_flat;
    end

`ifdef MATRIX_SER_CHECKSUM_EN
    // Running XOR of every data byte actually transferred in this frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                     csum_q <= '0;
        else if (capture)              csum_q <= '0;
        else if ((state == SEND) && xfer) csum_q <= csum_q ^ mux_byte;
    end
`endif

    elem_byte_mux #(
        .N_ELEM (N_ELEM),
        .ELEM_W (ELEM_W),
        .IDX_W  (IDX_W),
        .LANE_W (LANE_W)
    ) u_elem_byte_mux (
        .c_flat   (frame_q),
        .elem_idx (elem_idx),
        .lane     (lane),
        .byte_out (mux_byte)
    );

endmodule
